// File: rtl/decoder_nto2n_reg_if.sv
// Handshake bundle for decoder_nto2n_reg: code input side plus one-hot output side.
// err exists only when DEC_RANGE_ERR_EN is defined.
interface decoder_nto2n_reg_if #(
    parameter int IN_W    = 2,
    parameter int NUM_OUT = 4
);
    logic [IN_W-1:0]    in;
    logic               in_valid;
    logic               in_ready;
    logic [NUM_OUT-1:0] d;
    logic               out_valid;
    logic               out_ready;
`ifdef DEC_RANGE_ERR_EN
    logic               err;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, d, out_valid, err
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, d, out_valid, err
    );
`else
    modport master (
        output in, in_valid, out_ready,
        input  in_ready, d, out_valid
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, d, out_valid
    );
`endif
endinterface

// File: rtl/decoder_nto2n_reg.sv
// Registered binary-to-one-hot decoder with valid/ready handshake and level/pulse output mode.
// Optional macro DEC_RANGE_ERR_EN adds a registered out-of-range flag on bus.err.
module decoder_nto2n_reg #(
    parameter int IN_W    = 2,
    parameter int NUM_OUT = 4,
    parameter int MODE    = 0
) (
    input logic                i_clk,
    input logic                i_rst,
    decoder_nto2n_reg_if.slave bus
);
    // state   | meaning
    // S_EMPTY | no beat held, out_valid = 0
    // S_FULL  | unconsumed beat held in r_d, out_valid = 1
    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_OUT-1:0] r_d;
    logic [NUM_OUT-1:0] w_d_nxt;
    logic [NUM_OUT-1:0] w_dec;
    logic               w_out_valid;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_emit;

    if (IN_W < 1 || IN_W > 6) begin : g_bad_in_w
        $error("decoder_nto2n_reg: IN_W=%0d outside legal range 1..6", IN_W);
    end
    if (NUM_OUT < 1 || NUM_OUT > (1 << IN_W)) begin : g_bad_num_out
        $error("decoder_nto2n_reg: NUM_OUT=%0d illegal for IN_W=%0d", NUM_OUT, IN_W);
    end

    assign w_out_valid = (r_state == S_FULL);
    // Pass-through on drain keeps one code per cycle with a single register.
    assign w_in_ready  = !w_out_valid || bus.out_ready;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_emit      = w_out_valid && bus.out_ready;

    always_comb begin
        w_dec = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (bus.in == IN_W'(k)) begin
                w_dec[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        case (r_state)
            S_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = S_FULL;
                    w_d_nxt     = w_dec;
                end
            end
            S_FULL: begin
                if (w_accept) begin
                    w_d_nxt = w_dec;
                end else if (w_emit) begin
                    w_state_nxt = S_EMPTY;
                    if (MODE == 1) begin
                        w_d_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
                w_d_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_EMPTY;
            r_d     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.d         = r_d;

`ifdef DEC_RANGE_ERR_EN
    logic r_err;
    logic w_err_nxt;

    // An empty decode means the code had no matching output line.
    always_comb begin
        w_err_nxt = r_err;
        if (w_accept) begin
            w_err_nxt = ~|w_dec;
        end else if (w_emit) begin
            w_err_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign bus.err = r_err;
`endif
endmodule

// File: tb/tb_decoder_nto2n_reg.sv
// Self-checking bench for decoder_nto2n_reg: four parameterisations sharing one clock/reset.
// Honours DEC_RANGE_ERR_EN when the bundle is built with it.
module tb_decoder_nto2n_reg;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    decoder_nto2n_reg_if #(.IN_W(2), .NUM_OUT(4))  if0 ();
    decoder_nto2n_reg_if #(.IN_W(2), .NUM_OUT(4))  if1 ();
    decoder_nto2n_reg_if #(.IN_W(3), .NUM_OUT(5))  if2 ();
    decoder_nto2n_reg_if #(.IN_W(4), .NUM_OUT(16)) if3 ();

    decoder_nto2n_reg #(.IN_W(2), .NUM_OUT(4), .MODE(0))  u_dut0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
    decoder_nto2n_reg #(.IN_W(2), .NUM_OUT(4), .MODE(1))  u_dut1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
    decoder_nto2n_reg #(.IN_W(3), .NUM_OUT(5), .MODE(0))  u_dut2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));
    decoder_nto2n_reg #(.IN_W(4), .NUM_OUT(16), .MODE(0)) u_dut3 (.i_clk(clk), .i_rst(rst), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] exp_onehot(int code, int nout);
        return (code < nout) ? (64'd1 << code) : 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if0.in = 2'd3; if0.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        if0.in_valid = 1'b0;
        checks++; if (if0.d !== 4'b0 || if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_dut0: got d=%b ov=%b ir=%b expected d=0000 ov=0 ir=1", if0.d, if0.out_valid, if0.in_ready); end
        checks++; if (if1.d !== 4'b0 || if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_dut1: got d=%b ov=%b ir=%b expected d=0000 ov=0 ir=1", if1.d, if1.out_valid, if1.in_ready); end
        checks++; if (if2.d !== 5'b0 || if2.out_valid !== 1'b0 || if2.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_dut2: got d=%b ov=%b ir=%b expected d=00000 ov=0 ir=1", if2.d, if2.out_valid, if2.in_ready); end
        checks++; if (if3.d !== 16'b0 || if3.out_valid !== 1'b0 || if3.in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_dut3: got d=%h ov=%b ir=%b expected d=0000 ov=0 ir=1", if3.d, if3.out_valid, if3.in_ready); end
`ifdef DEC_RANGE_ERR_EN
        checks++; if (if2.err !== 1'b0) begin errors++;
            $display("FAIL reset_err: got %b expected 0", if2.err); end
`endif
    endtask

    task automatic test_sweep();
        if0.out_ready = 1'b1;
        if0.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if0.in = 2'(i);
            #1;
            checks++; if (if0.in_ready !== 1'b1) begin errors++;
                $display("FAIL sweep_ready: code %0d got %b expected 1", i, if0.in_ready); end
            tick();
            checks++; if (64'(if0.d) !== exp_onehot(i, 4) || if0.out_valid !== 1'b1) begin errors++;
                $display("FAIL sweep_d: code %0d got d=%b ov=%b expected d=%b ov=1", i, if0.d, if0.out_valid, exp_onehot(i, 4)); end
        end
        if0.in_valid = 1'b0;
        if0.in       = 'x;
        tick();
        checks++; if (if0.d !== 4'b1000 || if0.out_valid !== 1'b0) begin errors++;
            $display("FAIL sweep_hold: got d=%b ov=%b expected d=1000 ov=0", if0.d, if0.out_valid); end
        tick();
        checks++; if (if0.d !== 4'b1000) begin errors++;
            $display("FAIL sweep_x_idle: got d=%b expected 1000", if0.d); end
        if0.in = 2'd0;
    endtask

    task automatic test_backpressure();
        if0.in = 2'd2; if0.in_valid = 1'b1; if0.out_ready = 1'b0;
        tick();
        if0.in = 2'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (if0.in_ready !== 1'b0) begin errors++;
                $display("FAIL bp_ready: stall cycle %0d got %b expected 0", i, if0.in_ready); end
            tick();
            checks++; if (if0.d !== 4'b0100 || if0.out_valid !== 1'b1) begin errors++;
                $display("FAIL bp_stable: stall cycle %0d got d=%b ov=%b expected d=0100 ov=1", i, if0.d, if0.out_valid); end
        end
        if0.out_ready = 1'b1;
        #1;
        checks++; if (if0.in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_release_ready: got %b expected 1", if0.in_ready); end
        tick();
        if0.in_valid = 1'b0;
        checks++; if (if0.d !== 4'b0010 || if0.out_valid !== 1'b1) begin errors++;
            $display("FAIL bp_release_d: got d=%b ov=%b expected d=0010 ov=1", if0.d, if0.out_valid); end
        tick();
        checks++; if (if0.d !== 4'b0010 || if0.out_valid !== 1'b0) begin errors++;
            $display("FAIL bp_drain: got d=%b ov=%b expected d=0010 ov=0", if0.d, if0.out_valid); end
    endtask

    task automatic test_pulse();
        if1.in = 2'd3; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
        tick();
        if1.in_valid = 1'b0;
        checks++; if (if1.d !== 4'b1000 || if1.out_valid !== 1'b1) begin errors++;
            $display("FAIL pulse_on: got d=%b ov=%b expected d=1000 ov=1", if1.d, if1.out_valid); end
        tick();
        checks++; if (if1.d !== 4'b0000 || if1.out_valid !== 1'b0) begin errors++;
            $display("FAIL pulse_off: got d=%b ov=%b expected d=0000 ov=0", if1.d, if1.out_valid); end
        if1.in = 2'd1; if1.in_valid = 1'b1; if1.out_ready = 1'b0;
        tick();
        if1.in_valid = 1'b0;
        tick();
        checks++; if (if1.d !== 4'b0010 || if1.out_valid !== 1'b1) begin errors++;
            $display("FAIL pulse_stall: got d=%b ov=%b expected d=0010 ov=1", if1.d, if1.out_valid); end
        if1.out_ready = 1'b1;
        tick();
        checks++; if (if1.d !== 4'b0000 || if1.out_valid !== 1'b0) begin errors++;
            $display("FAIL pulse_stall_off: got d=%b ov=%b expected d=0000 ov=0", if1.d, if1.out_valid); end
    endtask

    task automatic test_out_of_range();
        if2.out_ready = 1'b1;
        if2.in = 3'd6; if2.in_valid = 1'b1;
        tick();
        if2.in = 3'd4;
        checks++; if (64'(if2.d) !== exp_onehot(6, 5) || if2.out_valid !== 1'b1) begin errors++;
            $display("FAIL oor_d: got d=%b ov=%b expected d=00000 ov=1", if2.d, if2.out_valid); end
`ifdef DEC_RANGE_ERR_EN
        checks++; if (if2.err !== 1'b1) begin errors++;
            $display("FAIL oor_err_set: got %b expected 1", if2.err); end
`endif
        tick();
        if2.in = 3'd7;
        checks++; if (64'(if2.d) !== exp_onehot(4, 5) || if2.out_valid !== 1'b1) begin errors++;
            $display("FAIL oor_inrange_d: got d=%b ov=%b expected d=10000 ov=1", if2.d, if2.out_valid); end
`ifdef DEC_RANGE_ERR_EN
        checks++; if (if2.err !== 1'b0) begin errors++;
            $display("FAIL oor_err_clr: got %b expected 0", if2.err); end
`endif
        tick();
        if2.in_valid = 1'b0;
        checks++; if (if2.d !== 5'b0 || if2.out_valid !== 1'b1) begin errors++;
            $display("FAIL oor_7_d: got d=%b ov=%b expected d=00000 ov=1", if2.d, if2.out_valid); end
        tick();
        checks++; if (if2.out_valid !== 1'b0 || if2.d !== 5'b0) begin errors++;
            $display("FAIL oor_drain: got d=%b ov=%b expected d=00000 ov=0", if2.d, if2.out_valid); end
`ifdef DEC_RANGE_ERR_EN
        checks++; if (if2.err !== 1'b0) begin errors++;
            $display("FAIL oor_err_drain: got %b expected 0", if2.err); end
`endif
    endtask

    task automatic test_reset_mid();
        if0.in = 2'd2; if0.in_valid = 1'b1; if0.out_ready = 1'b0;
        tick();
        checks++; if (if0.d !== 4'b0100 || if0.out_valid !== 1'b1) begin errors++;
            $display("FAIL rstmid_pre: got d=%b ov=%b expected d=0100 ov=1", if0.d, if0.out_valid); end
        if0.in = 2'd1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if0.in_valid = 1'b0;
        checks++; if (if0.d !== 4'b0 || if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin errors++;
            $display("FAIL rstmid_post: got d=%b ov=%b ir=%b expected d=0000 ov=0 ir=1", if0.d, if0.out_valid, if0.in_ready); end
        tick();
        checks++; if (if0.d !== 4'b0 || if0.out_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_nodecode: got d=%b ov=%b expected d=0000 ov=0", if0.d, if0.out_valid); end
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic [15:0] last;
        logic        v;
        logic        r;
        logic        exp_ready;
        logic [3:0]  c;
        int          accepted;
        int          cyc;
        last     = '0;
        accepted = 0;
        cyc      = 0;
        while ((accepted < 200 || q.size() != 0) && cyc < 4000) begin
            if (accepted < 200) begin
                v = 1'($urandom_range(0, 1));
                c = 4'($urandom_range(0, 15));
            end else begin
                v = 1'b0;
                c = 4'd0;
            end
            r = ($urandom_range(0, 3) != 0);
            if3.in = c; if3.in_valid = v; if3.out_ready = r;
            #1;
            exp_ready = (q.size() == 0) || r;
            checks++; if (if3.in_ready !== exp_ready) begin errors++;
                $display("FAIL rand_ready: cycle %0d got %b expected %b", cyc, if3.in_ready, exp_ready); end
            checks++;
            if (q.size() != 0) begin
                if (if3.out_valid !== 1'b1 || if3.d !== q[0]) begin errors++;
                    $display("FAIL rand_beat: cycle %0d got d=%h ov=%b expected d=%h ov=1", cyc, if3.d, if3.out_valid, q[0]); end
            end else begin
                if (if3.out_valid !== 1'b0 || if3.d !== last) begin errors++;
                    $display("FAIL rand_idle: cycle %0d got d=%h ov=%b expected d=%h ov=0", cyc, if3.d, if3.out_valid, last); end
            end
            if (q.size() != 0 && r) last = q.pop_front();
            if (v && exp_ready) begin
                q.push_back(16'(exp_onehot(int'(c), 16)));
                accepted++;
            end
            tick();
            cyc++;
        end
        if3.in_valid = 1'b0;
        checks++; if (accepted != 200 || q.size() != 0) begin errors++;
            $display("FAIL rand_timeout: got accepted=%0d pending=%0d after %0d cycles expected 200 and 0", accepted, q.size(), cyc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        if0.in = '0; if0.in_valid = 1'b0; if0.out_ready = 1'b0;
        if1.in = '0; if1.in_valid = 1'b0; if1.out_ready = 1'b0;
        if2.in = '0; if2.in_valid = 1'b0; if2.out_ready = 1'b0;
        if3.in = '0; if3.in_valid = 1'b0; if3.out_ready = 1'b0;
        test_reset();
        test_sweep();
        test_backpressure();
        test_pulse();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
